// File: rtl/i_cache_pkg.sv
// Shared definitions for the N-way instruction cache: FSM encodings, XLEN, address-field helpers.
package i_cache_pkg;

    localparam int XLEN = 32;

    localparam logic [0:0] COMPARE_TAG = 1'b0;
    localparam logic [0:0] ALLOCATE    = 1'b1;

    // Returns 0 for 1 so that single-word blocks and direct-mapped builds elaborate.
    function automatic int clog2_safe(input int v);
        return (v <= 1) ? 0 : $clog2(v);
    endfunction

    function automatic int idx_lsb(input int m);
        return m + 2;
    endfunction

    function automatic int tag_lsb(input int m, input int n);
        return m + n + 2;
    endfunction

endpackage

// File: rtl/i_cache_way.sv
// One cache way: valid/tag/data arrays, combinational read and tag compare by index.
// Latency: read and hit are combinational; writes and global clear land on the clock edge.
// Backpressure: none here, the top sequences all writes.
module i_cache_way #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6,
    parameter int TAG_W   = 22,
    parameter int BLK_W   = 128
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_we,
    input  logic             i_wr_valid,
    input  logic [BLK_W-1:0] i_wr_data,
    input  logic             i_clr,
    output logic             o_valid,
    output logic             o_hit,
    output logic [BLK_W-1:0] o_data
);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [BLK_W-1:0]   data_q [ENTRIES];

    assign o_valid = valid_q[i_idx];
    assign o_hit   = valid_q[i_idx] && (tag_q[i_idx] == i_tag);
    assign o_data  = data_q[i_idx];

    // The global clear wins over a fill into the same edge.
    always_comb begin
        valid_d = valid_q;
        if (i_we) begin
            valid_d[i_idx] = i_wr_valid;
        end
        if (i_clr) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            tag_q[i_idx]  <= i_tag;
            data_q[i_idx] <= i_wr_data;
        end
    end

endmodule

// File: rtl/i_cache_nway.sv
// N-way set-associative instruction cache with round-robin replacement and whole-cache flush.
// Latency: hits are combinational; a miss stalls for detect + fill wait + one re-compare cycle.
// Backpressure: o_Stall holds the fetch stage; fills wait on i_MemReady while o_DataReq is high.
module i_cache_nway
    import i_cache_pkg::*;
#(
    parameter int BLOCK_SIZE = 4,
    parameter int ENTRIES    = 64,
    parameter int WAYS       = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [BLOCK_SIZE*32-1:0] i_DataBlock,
    input  logic                     i_MemReady,
    output logic                     o_DataReq,
    output logic [XLEN-1:0]          o_MemAddr,
    input  logic [XLEN-1:0]          i_Addr,
    input  logic                     i_Flush,
    output logic [XLEN-1:0]          o_Data,
    output logic                     o_Stall,
    output logic                     o_Hit
);

    localparam int M     = clog2_safe(BLOCK_SIZE);
    localparam int N     = clog2_safe(ENTRIES);
    localparam int WB    = clog2_safe(WAYS);
    localparam int PW    = (WB > 0) ? WB : 1;
    localparam int TAG_W = XLEN - tag_lsb(M, N);
    localparam int BLK_W = BLOCK_SIZE * 32;

    logic [N-1:0]     idx;
    logic [TAG_W-1:0] tag;
    assign idx = i_Addr[idx_lsb(M) +: N];
    assign tag = i_Addr[XLEN-1 -: TAG_W];

    logic             unused_bits;
    assign unused_bits = ^i_Addr[1:0];

    logic [WAYS-1:0]  way_valid, way_hit, way_we;
    logic [BLK_W-1:0] way_data [WAYS];
    logic             fill_we, fill_valid, clr_all;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        i_cache_way #(
            .ENTRIES (ENTRIES),
            .IDX_W   (N),
            .TAG_W   (TAG_W),
            .BLK_W   (BLK_W)
        ) u_way (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_idx      (idx),
            .i_tag      (tag),
            .i_we       (way_we[w]),
            .i_wr_valid (fill_valid),
            .i_wr_data  (i_DataBlock),
            .i_clr      (clr_all),
            .o_valid    (way_valid[w]),
            .o_hit      (way_hit[w]),
            .o_data     (way_data[w])
        );
    end

    logic             hit_any;
    logic [BLK_W-1:0] hit_blk;
    always_comb begin
        hit_any = 1'b0;
        hit_blk = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                hit_any = 1'b1;
                hit_blk = hit_blk | way_data[w];
            end
        end
    end

    if (M > 0) begin : g_word
        logic [M-1:0] word;
        assign word   = i_Addr[2 +: M];
        assign o_Data = hit_blk[word*32 +: 32];
    end else begin : g_noword
        assign o_Data = hit_blk[31:0];
    end

    logic [PW-1:0] ptr_q [ENTRIES];
    logic [PW-1:0] victim, ptr_nxt;
    logic          all_valid, ptr_adv;

    // Lowest-numbered invalid way wins; the pointer only picks among full sets.
    always_comb begin
        victim    = ptr_q[idx];
        all_valid = &way_valid;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim = PW'(w);
            end
        end
        ptr_nxt = (WAYS > 1) ? ptr_q[idx] + PW'(1) : '0;
        for (int w = 0; w < WAYS; w++) begin
            way_we[w] = fill_we && (victim == PW'(w));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int e = 0; e < ENTRIES; e++) begin
                ptr_q[e] <= '0;
            end
        end else if (ptr_adv) begin
            ptr_q[idx] <= ptr_nxt;
        end
    end

    logic [0:0] state_q, state_d;
    logic       flush_pend_q, flush_pend_d;
    logic       refill_q, refill_d;

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        refill_d     = 1'b0;
        o_Stall      = 1'b1;
        o_Hit        = 1'b0;
        o_DataReq    = 1'b0;
        fill_we      = 1'b0;
        fill_valid   = 1'b0;
        clr_all      = 1'b0;
        ptr_adv      = 1'b0;
        case (state_q)
            COMPARE_TAG: begin
                // The cycle right after a fill is the re-compare; it stalls even on a hit.
                if (i_Flush) begin
                    clr_all = 1'b1;
                end else if (hit_any && !refill_q) begin
                    o_Stall = 1'b0;
                    o_Hit   = 1'b1;
                end else if (!hit_any) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                o_DataReq = 1'b1;
                if (i_Flush) begin
                    flush_pend_d = 1'b1;
                end
                if (i_MemReady) begin
                    fill_we      = 1'b1;
                    fill_valid   = !(flush_pend_q || i_Flush);
                    clr_all      = flush_pend_q || i_Flush;
                    flush_pend_d = 1'b0;
                    ptr_adv      = all_valid;
                    refill_d     = 1'b1;
                    state_d      = COMPARE_TAG;
                end
            end
            default: state_d = COMPARE_TAG;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= COMPARE_TAG;
            flush_pend_q <= 1'b0;
            refill_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            refill_q     <= refill_d;
        end
    end

    assign o_MemAddr = {i_Addr[XLEN-1:M+2], {(M+2){1'b0}}};

endmodule
